// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses pll_rst, waits for a qualified lock, then releases sys_rst.
// Define PLL_SEQ_RETRY_LIMIT_EN to enter FAIL after MAX_RETRIES consecutive lock timeouts.
module pll_reset_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRIES  = 4,
  parameter int CNT_W        = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic [2:0]       seq_state,
  output logic [CNT_W-1:0] relock_cnt,
  output logic             timeout_err,
  output logic             fail
);

  // One shared width covers the phase counter and the retry counter.
  localparam int M1      = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int M2      = (LOCK_STABLE > MAX_RETRIES) ? LOCK_STABLE : MAX_RETRIES;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int TW      = $clog2(CNT_MAX + 1);

  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE - 1);

  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] relock_d;
  logic             timeout_d;
  logic             lock_meta, lock_s;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  logic [TW-1:0]    retry_q, retry_d;
`endif

  assign seq_state = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    relock_d  = relock_cnt;
    timeout_d = timeout_err;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    retry_d   = retry_q;
`endif
    // A software request overrides everything, including a same-cycle lock loss.
    if (relock_req) begin
      state_d = RST_ASSERT;
      cnt_d   = '0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      if (state_q == FAIL) retry_d = '0;
`endif
    end else begin
      case (state_q)
        RST_ASSERT: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = RST_ASSERT;
            cnt_d     = '0;
            timeout_d = 1'b1;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            retry_d = retry_q + TW'(1);
            if (retry_d == TW'(MAX_RETRIES)) state_d = FAIL;
`endif
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            retry_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = RST_ASSERT;
            cnt_d   = '0;
            if (relock_cnt != '1) relock_d = relock_cnt + CNT_W'(1);
          end
        end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        FAIL: state_d = FAIL;
`endif
        default: begin
          state_d = RST_ASSERT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Resets are decoded from the next state so they change on the same edge as seq_state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= RST_ASSERT;
      cnt_q       <= '0;
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      relock_cnt  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_meta   <= pll_locked;
      lock_s      <= lock_meta;
      pll_rst     <= (state_d == RST_ASSERT) || (state_d == FAIL);
      sys_rst     <= (state_d != RUN);
      relock_cnt  <= relock_d;
      timeout_err <= timeout_d;
    end
  end

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  always_ff @(posedge refclk) begin
    if (rst) begin
      retry_q <= '0;
      fail    <= 1'b0;
    end else begin
      retry_q <= retry_d;
      fail    <= (state_d == FAIL);
    end
  end
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a scoreboard of expected values.
// Covers both builds of PLL_SEQ_RETRY_LIMIT_EN.
module tb_pll_reset_sequencer;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int LS = 8;
  localparam int MR = 2;
  localparam int CW = 8;

  localparam int SEL_STATE   = 0;
  localparam int SEL_PLL_RST = 1;
  localparam int SEL_SYS_RST = 2;
  localparam int SEL_RELOCK  = 3;
  localparam int SEL_TERR    = 4;
  localparam int SEL_FAIL    = 5;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst, sys_rst, timeout_err, fail;
  logic [2:0]    seq_state;
  logic [CW-1:0] relock_cnt;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  seen = '0;

  pll_reset_sequencer #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS),
    .MAX_RETRIES(MR), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .seq_state(seq_state),
    .relock_cnt(relock_cnt), .timeout_err(timeout_err), .fail(fail)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
    seen[seq_state] = 1'b1;
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      SEL_STATE:   return {29'd0, seq_state};
      SEL_PLL_RST: return {31'd0, pll_rst};
      SEL_SYS_RST: return {31'd0, sys_rst};
      SEL_RELOCK:  return {24'd0, relock_cnt};
      SEL_TERR:    return {31'd0, timeout_err};
      SEL_FAIL:    return {31'd0, fail};
      default:     return '0;
    endcase
  endfunction

  task automatic push_expect(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag   = tag;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.value) else begin
        bad++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic check_sig(input int sel);
    check_output(probe(sel));
  endtask

  task automatic check_ok(input int n);
    check_output((n >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic push_reset_values(input string p);
    push_expect({p, "_state"}, 0);
    push_expect({p, "_pll_rst"}, 1);
    push_expect({p, "_sys_rst"}, 1);
    push_expect({p, "_relock_cnt"}, 0);
    push_expect({p, "_timeout_err"}, 0);
    push_expect({p, "_fail"}, 0);
  endtask

  task automatic check_all();
    for (int s = SEL_STATE; s <= SEL_FAIL; s++) check_sig(s);
  endtask

  // n = edges taken until the signal shows val, or -1 if the budget ran out
  task automatic wait_until(input int sel, input logic [31:0] val, input int budget, output int n);
    n = 0;
    while (probe(sel) !== val && n < budget) begin
      tick();
      n++;
    end
    if (probe(sel) !== val) n = -1;
  endtask

  initial begin
    int n;
    int ok;
    logic [31:0] cnt_at_100, cnt_at_255;

    $display("[TB] power-up reset");
    push_reset_values("por");
    tick();
    tick();
    check_all();

    $display("[TB] scenario 1: clean power-up");
    rst  = 1'b0;
    seen = '0;
    push_expect("t1_pll_rst_cycles", RC);
    wait_until(SEL_PLL_RST, 0, 50, n);
    check_output(n);
    push_expect("t1_state_wait", 1);
    check_sig(SEL_STATE);
    tick();
    pll_locked = 1'b1;
    tick();
    // counted from the first edge that samples pll_locked high
    push_expect("t1_release_cycles", 2 + LS);
    wait_until(SEL_SYS_RST, 0, 100, n);
    check_output(n);
    push_expect("t1_state_run", 3);
    check_sig(SEL_STATE);
    push_expect("t1_states_seen", 8'b0000_1111);
    check_output({24'd0, seen});
    push_expect("t1_relock_cnt", 0);
    check_sig(SEL_RELOCK);

    $display("[TB] scenario 2: lock glitch in STABLE");
    rst        = 1'b1;
    pll_locked = 1'b0;
    push_reset_values("t2_rst_in_run");
    tick();
    check_all();
    rst = 1'b0;
    push_expect("t2_reach_wait", 1);
    wait_until(SEL_STATE, 1, 50, n);
    check_ok(n);
    pll_locked = 1'b1;
    repeat (5) tick();
    push_expect("t2_in_stable", 2);
    check_sig(SEL_STATE);
    seen       = '0;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    push_expect("t2_release_cycles", 2 + LS);
    wait_until(SEL_SYS_RST, 0, 100, n);
    check_output(n);
    push_expect("t2_back_to_wait", 1);
    check_output({31'd0, seen[1]});
    push_expect("t2_timeout_err", 0);
    check_sig(SEL_TERR);

    $display("[TB] scenario 3: lock timeout");
    rst        = 1'b1;
    pll_locked = 1'b0;
    tick();
    rst = 1'b0;
    push_expect("t3_pll_rst_cycles", RC);
    wait_until(SEL_PLL_RST, 0, 50, n);
    check_output(n);
    push_expect("t3_wait_cycles_1", LT);
    wait_until(SEL_STATE, 0, 100, n);
    check_output(n);
    push_expect("t3_timeout_err", 1);
    check_sig(SEL_TERR);
    push_expect("t3_repulse_cycles", RC);
    wait_until(SEL_PLL_RST, 0, 50, n);
    check_output(n);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    push_expect("t3_wait_cycles_2", LT);
    wait_until(SEL_STATE, 4, 100, n);
    check_output(n);
    push_expect("t3_fail", 1);
    check_sig(SEL_FAIL);
    repeat (5) tick();
    push_expect("t3_fail_state_held", 4);
    check_sig(SEL_STATE);
    push_expect("t3_fail_pll_rst", 1);
    check_sig(SEL_PLL_RST);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    push_expect("t5_req_in_fail_state", 0);
    check_sig(SEL_STATE);
    push_expect("t5_req_in_fail_clears", 0);
    check_sig(SEL_FAIL);
`else
    push_expect("t3_wait_cycles_2", LT);
    wait_until(SEL_STATE, 0, 100, n);
    check_output(n);
    push_expect("t3_no_fail", 0);
    check_sig(SEL_FAIL);
    push_expect("t3_retry_pll_rst", 1);
    check_sig(SEL_PLL_RST);
`endif

    $display("[TB] scenario 4: lock loss in RUN");
    pll_locked = 1'b1;
    push_expect("t4_reach_run", 1);
    wait_until(SEL_STATE, 3, 100, n);
    check_ok(n);
    pll_locked = 1'b0;
    push_expect("t4_sys_rst_latency", 3);
    wait_until(SEL_SYS_RST, 1, 10, n);
    check_output(n);
    push_expect("t4_relock_cnt", 1);
    check_sig(SEL_RELOCK);
    push_expect("t4_state_restart", 0);
    check_sig(SEL_STATE);
    push_expect("t4_timeout_err_sticky", 1);
    check_sig(SEL_TERR);

    $display("[TB] scenario 5: relock request in RUN");
    pll_locked = 1'b1;
    push_expect("t5_reach_run", 1);
    wait_until(SEL_STATE, 3, 100, n);
    check_ok(n);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    push_expect("t5_sys_rst", 1);
    check_sig(SEL_SYS_RST);
    push_expect("t5_relock_cnt_kept", 1);
    check_sig(SEL_RELOCK);
    push_expect("t5_pll_rst_cycles", RC);
    wait_until(SEL_PLL_RST, 0, 50, n);
    check_output(n);
    push_expect("t5_reach_run_again", 1);
    wait_until(SEL_STATE, 3, 100, n);
    check_ok(n);
    pll_locked = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    push_expect("t5_req_beats_loss_state", 0);
    check_sig(SEL_STATE);
    push_expect("t5_req_beats_loss_cnt", 1);
    check_sig(SEL_RELOCK);

    $display("[TB] scenario 6: reset in STABLE");
    pll_locked = 1'b1;
    push_expect("t6_reach_stable", 1);
    wait_until(SEL_STATE, 2, 100, n);
    check_ok(n);
    tick();
    tick();
    rst = 1'b1;
    push_reset_values("t6_stable");
    tick();
    check_all();
    rst = 1'b0;

    $display("[TB] scenario 4b: relock counter saturation");
    ok         = 1;
    cnt_at_100 = '0;
    cnt_at_255 = '0;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      wait_until(SEL_STATE, 3, 100, n);
      if (n < 0) begin ok = 0; break; end
      pll_locked = 1'b0;
      wait_until(SEL_SYS_RST, 1, 10, n);
      if (n < 0) begin ok = 0; break; end
      if (i == 99)  cnt_at_100 = probe(SEL_RELOCK);
      if (i == 254) cnt_at_255 = probe(SEL_RELOCK);
    end
    push_expect("t4_loop_waits", 1);
    check_output(ok);
    push_expect("t4_relock_cnt_100", 100);
    check_output(cnt_at_100);
    push_expect("t4_relock_cnt_255", 255);
    check_output(cnt_at_255);
    push_expect("t4_relock_cnt_saturated", 255);
    check_sig(SEL_RELOCK);

    $display("[TB] scenario 6b: reset in RUN");
    pll_locked = 1'b1;
    push_expect("t6_reach_run", 1);
    wait_until(SEL_STATE, 3, 100, n);
    check_ok(n);
    rst = 1'b1;
    push_reset_values("t6_run");
    tick();
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the reset of the on-chip PLL and generates the synchronous system reset for logic clocked by the PLL outputs.
- Runs on the free-running PLL reference clock.
- Sequence: holds the PLL in reset, waits for lock with a timeout, qualifies lock as stable, then releases the downstream reset.
- Loss of lock, a timeout or a software request re-runs the full sequence.

Parameters:
- RST_CYCLES, 16: number of refclk cycles pll_rst is held high per reset attempt (min 1).
- LOCK_TIMEOUT, 50000: max refclk cycles spent in WAIT_LOCK before a retry (min 1).
- LOCK_STABLE, 256: consecutive refclk cycles the synced lock must stay high before release (min 1).
- MAX_RETRIES, 4: consecutive timeouts tolerated before FAIL (only with PLL_SEQ_RETRY_LIMIT_EN).
- CNT_W, 8: width of relock_cnt.

Ports:
- refclk  input  1  single clock, free-running PLL reference.
- rst  input  1  synchronous, active-high reset.
- pll_locked  input  1  raw PLL lock, asynchronous to refclk.
- relock_req  input  1  single-cycle request to restart the sequence.
- pll_rst  output  1  reset to the PLL, active-high.
- sys_rst  output  1  downstream reset, active-high, synchronous to refclk.
- seq_state  output  3  current state encoding.
- relock_cnt  output  CNT_W  count of lock losses seen in RUN, saturating.
- timeout_err  output  1  sticky flag: at least one lock timeout has occurred.
- fail  output  1  retry limit exhausted; tied 0 without the macro.

Behaviour:
- Clock and reset: one clock, refclk. rst is synchronous and active-high. All outputs are registered.
- Reset values (rst high on a rising edge):
  - state = RST_ASSERT, all counters 0.
  - pll_rst = 1, sys_rst = 1.
  - relock_cnt = 0, timeout_err = 0, fail = 0.
  - Both synchroniser flops = 0.
- Lock synchroniser: pll_locked passes through 2 flops to give lock_s. Latency is 2 cycles. Only lock_s is used.
- State encoding: RST_ASSERT = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3, FAIL = 4.
- RST_ASSERT:
  - pll_rst = 1, sys_rst = 1.
  - The counter runs 0 to RST_CYCLES-1.
  - On the final count: go to WAIT_LOCK and clear the counter. pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst = 0, sys_rst = 1. The counter increments each cycle.
  - lock_s = 1: go to STABLE and clear the counter.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s = 0: set timeout_err, increment the retry counter, go to RST_ASSERT.
  - If lock_s rises on the timeout cycle itself, the lock wins and the state goes to STABLE.
- STABLE:
  - pll_rst = 0, sys_rst = 1.
  - lock_s = 0: go to WAIT_LOCK with the counter cleared. The timeout restarts fully.
  - LOCK_STABLE consecutive cycles with lock_s = 1: go to RUN and clear the retry counter.
  - sys_rst falls on the cycle RUN is entered.
- RUN:
  - pll_rst = 0, sys_rst = 0.
  - lock_s = 0: sys_rst = 1 on the next edge, relock_cnt increments (saturating at all-ones), go to RST_ASSERT.
- relock_req:
  - In any state except FAIL: go to RST_ASSERT with the counter cleared and sys_rst = 1 next cycle. relock_cnt is not incremented.
  - If relock_req and a lock loss occur in RUN in the same cycle, the request wins: no increment.
- rst mid-sequence: returns to the reset values on the next edge regardless of state. timeout_err and relock_cnt are cleared only by rst.
- FAIL: only reachable with the macro defined (see Optional Feature).

Optional Feature:
- Macro: PLL_SEQ_RETRY_LIMIT_EN.
- Defined:
  - When a timeout makes the consecutive-timeout count equal MAX_RETRIES, enter FAIL instead of RST_ASSERT.
  - In FAIL: pll_rst = 1, sys_rst = 1, fail = 1.
  - FAIL is left only by rst, or by relock_req, which goes to RST_ASSERT and clears fail and the retry counter.
- Not defined: retries continue forever, FAIL is unreachable, fail is constant 0, and the retry counter is not compiled in.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
1. Power-up, pll_locked rises 5 cycles after rst release and stays high -> pll_rst high exactly 4 cycles. sys_rst falls 2+8 cycles after pll_locked rises. seq_state passes 0,1,2,3. relock_cnt = 0.
2. Lock glitch: pll_locked high 5 cycles, low 1 cycle, then high while in STABLE -> return to WAIT_LOCK. sys_rst stays 1 until 8 clean cycles. timeout_err = 0.
3. pll_locked held low -> timeout after 20 WAIT_LOCK cycles, timeout_err = 1, pll_rst re-pulses for 4 cycles. With the macro: fail = 1 after the 2nd timeout and pll_rst is held high.
4. In RUN, drop pll_locked -> sys_rst = 1 within 3 cycles of the drop, relock_cnt = 1, sequence restarts. Repeat 300 times with CNT_W=8 -> relock_cnt saturates at 255.
5. relock_req pulsed in RUN -> sys_rst = 1 next cycle, pll_rst high 4 cycles, relock_cnt unchanged. relock_req in FAIL -> fail = 0 and state goes to RST_ASSERT.
6. rst asserted mid-STABLE and mid-RUN -> next edge gives all outputs their reset values: pll_rst = 1, sys_rst = 1, flags = 0.
